// File: rtl/bus_sequencer.sv
// Control sequencer for the single-bus datapath: walks one instruction through
// fetch, decode, execute and writeback, asserting bus-drive, load and ALU strobes.
module bus_sequencer #(
    parameter int NREG = 16,
    parameter int OPW  = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            mem_ready,
    input  logic [31:0]     ir,
    output logic            busy,
    output logic            done,
    output logic            illegal,
    output logic [NREG-1:0] reg_out,
    output logic [NREG-1:0] reg_in,
    output logic            pc_out,
    output logic            pc_in,
    output logic            inc_pc,
    output logic            ir_in,
    output logic            mar_in,
    output logic            mdr_in,
    output logic            mdr_out,
    output logic            mem_read,
    output logic            y_in,
    output logic            z_in,
    output logic            zlo_out,
    output logic            zhi_out,
    output logic            hi_in,
    output logic            lo_in,
    output logic [OPW-1:0]  alu_op
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T0   = 3'd1;
    localparam logic [2:0] S_T1   = 3'd2;
    localparam logic [2:0] S_T2   = 3'd3;
    localparam logic [2:0] S_T3   = 3'd4;
    localparam logic [2:0] S_T4   = 3'd5;
    localparam logic [2:0] S_T5   = 3'd6;
    localparam logic [2:0] S_T6   = 3'd7;

    logic [2:0]     state_q, state_d;
    logic [OPW-1:0] opcode;
    logic [3:0]     ra, rb, rc;
    logic           is_r3, is_r2, is_md;
    logic           unused_ir;

    assign opcode    = ir[31 -: OPW];
    assign ra        = ir[26:23];
    assign rb        = ir[22:19];
    assign rc        = ir[18:15];
    assign unused_ir = ^ir[14:0];

    function automatic logic [NREG-1:0] onehot(input logic [3:0] idx);
        logic [NREG-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    always_comb begin
        is_r3 = 1'b0;
        is_r2 = 1'b0;
        is_md = 1'b0;
        case (opcode)
            OPW'(3), OPW'(4), OPW'(5), OPW'(6),
            OPW'(7), OPW'(8), OPW'(9), OPW'(10): is_r3 = 1'b1;
            OPW'(17), OPW'(18):                  is_r2 = 1'b1;
            OPW'(15), OPW'(16):                  is_md = 1'b1;
            default: ;
        endcase
    end

    // Every state drives at most one bus source; unknown opcodes finish in T3 with no strobes.
    always_comb begin
        state_d  = state_q;
        done     = 1'b0;
        illegal  = 1'b0;
        reg_out  = '0;
        reg_in   = '0;
        pc_out   = 1'b0;
        pc_in    = 1'b0;
        inc_pc   = 1'b0;
        ir_in    = 1'b0;
        mar_in   = 1'b0;
        mdr_in   = 1'b0;
        mdr_out  = 1'b0;
        mem_read = 1'b0;
        y_in     = 1'b0;
        z_in     = 1'b0;
        zlo_out  = 1'b0;
        zhi_out  = 1'b0;
        hi_in    = 1'b0;
        lo_in    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_T0;
            end
            S_T0: begin
                pc_out  = 1'b1;
                mar_in  = 1'b1;
                inc_pc  = 1'b1;
                z_in    = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                zlo_out  = 1'b1;
                mem_read = 1'b1;
                // PC loads only on the exit cycle so a stalled fetch updates it once.
                if (mem_ready) begin
                    pc_in   = 1'b1;
                    mdr_in  = 1'b1;
                    state_d = S_T2;
                end
            end
            S_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                if (is_r3) begin
                    reg_out = onehot(rb);
                    y_in    = 1'b1;
                    state_d = S_T4;
                end else if (is_r2) begin
                    reg_out = onehot(rb);
                    z_in    = 1'b1;
                    state_d = S_T4;
                end else if (is_md) begin
                    reg_out = onehot(ra);
                    y_in    = 1'b1;
                    state_d = S_T4;
                end else begin
                    done    = 1'b1;
                    illegal = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_T4: begin
                if (is_r3) begin
                    reg_out = onehot(rc);
                    z_in    = 1'b1;
                    state_d = S_T5;
                end else if (is_r2) begin
                    zlo_out = 1'b1;
                    reg_in  = onehot(ra);
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else if (is_md) begin
                    reg_out = onehot(rb);
                    z_in    = 1'b1;
                    state_d = S_T5;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_T5: begin
                if (is_r3) begin
                    zlo_out = 1'b1;
                    reg_in  = onehot(ra);
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else if (is_md) begin
                    zlo_out = 1'b1;
                    lo_in   = 1'b1;
                    state_d = S_T6;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_T6: begin
                zhi_out = 1'b1;
                hi_in   = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy   = (state_q != S_IDLE);
        alu_op = (z_in && !inc_pc) ? opcode : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed self-checking bench for bus_sequencer: per-cycle strobe snapshots
// compared against hand-derived expectations, plus a bus invariant monitor.
module tb_bus_sequencer;

    localparam int MAXC = 20;

    localparam logic [16:0] S_PC_OUT   = 17'h10000;
    localparam logic [16:0] S_PC_IN    = 17'h08000;
    localparam logic [16:0] S_INC_PC   = 17'h04000;
    localparam logic [16:0] S_IR_IN    = 17'h02000;
    localparam logic [16:0] S_MAR_IN   = 17'h01000;
    localparam logic [16:0] S_MDR_IN   = 17'h00800;
    localparam logic [16:0] S_MDR_OUT  = 17'h00400;
    localparam logic [16:0] S_MEM_READ = 17'h00200;
    localparam logic [16:0] S_Y_IN     = 17'h00100;
    localparam logic [16:0] S_Z_IN     = 17'h00080;
    localparam logic [16:0] S_ZLO_OUT  = 17'h00040;
    localparam logic [16:0] S_ZHI_OUT  = 17'h00020;
    localparam logic [16:0] S_HI_IN    = 17'h00010;
    localparam logic [16:0] S_LO_IN    = 17'h00008;
    localparam logic [16:0] S_DONE     = 17'h00004;
    localparam logic [16:0] S_ILLEGAL  = 17'h00002;
    localparam logic [16:0] S_BUSY     = 17'h00001;

    localparam logic [16:0] E_T0 = S_PC_OUT | S_MAR_IN | S_INC_PC | S_Z_IN | S_BUSY;
    localparam logic [16:0] E_T1 = S_ZLO_OUT | S_PC_IN | S_MEM_READ | S_MDR_IN | S_BUSY;
    localparam logic [16:0] E_T1_STALL = S_ZLO_OUT | S_MEM_READ | S_BUSY;
    localparam logic [16:0] E_T2 = S_MDR_OUT | S_IR_IN | S_BUSY;

    logic        clk = 1'b0;
    logic        reset, start, mem_ready;
    logic [31:0] ir;
    logic        busy, done, illegal;
    logic [15:0] reg_out, reg_in;
    logic        pc_out, pc_in, inc_pc, ir_in, mar_in, mdr_in, mdr_out, mem_read;
    logic        y_in, z_in, zlo_out, zhi_out, hi_in, lo_in;
    logic [4:0]  alu_op;

    int checks = 0;
    int errors = 0;
    logic monitor_on = 1'b0;

    logic [16:0] s_str [1:MAXC];
    logic [15:0] s_ro  [1:MAXC];
    logic [15:0] s_ri  [1:MAXC];
    logic [4:0]  s_alu [1:MAXC];
    int          ncyc;
    int          cnt_mem_read, cnt_pc_in, cnt_mdr_in;
    logic        any_load;
    logic [16:0] idle1_str, idle2_str;

    bus_sequencer #(.NREG(16), .OPW(5)) dut (
        .clk(clk), .reset(reset), .start(start), .mem_ready(mem_ready), .ir(ir),
        .busy(busy), .done(done), .illegal(illegal),
        .reg_out(reg_out), .reg_in(reg_in),
        .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .ir_in(ir_in),
        .mar_in(mar_in), .mdr_in(mdr_in), .mdr_out(mdr_out), .mem_read(mem_read),
        .y_in(y_in), .z_in(z_in), .zlo_out(zlo_out), .zhi_out(zhi_out),
        .hi_in(hi_in), .lo_in(lo_in), .alu_op(alu_op)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] obs_strobes();
        return {pc_out, pc_in, inc_pc, ir_in, mar_in, mdr_in, mdr_out, mem_read,
                y_in, z_in, zlo_out, zhi_out, hi_in, lo_in, done, illegal, busy};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " str"}, 32'(obs_strobes()), 32'd0);
        checkOutput({tag, " ro"}, 32'(reg_out), 32'd0);
        checkOutput({tag, " ri"}, 32'(reg_in), 32'd0);
        checkOutput({tag, " alu"}, 32'(alu_op), 32'd0);
    endtask

    task automatic checkCycle(input string tag, input int k, input logic [16:0] e_str,
                              input logic [15:0] e_ro, input logic [15:0] e_ri, input logic [4:0] e_alu);
        checkOutput($sformatf("%s c%0d str", tag, k), 32'(s_str[k]), 32'(e_str));
        checkOutput($sformatf("%s c%0d ro", tag, k), 32'(s_ro[k]), 32'(e_ro));
        checkOutput($sformatf("%s c%0d ri", tag, k), 32'(s_ri[k]), 32'(e_ri));
        checkOutput($sformatf("%s c%0d alu", tag, k), 32'(s_alu[k]), 32'(e_alu));
    endtask

    // Runs one instruction from IDLE, recording every cycle until done; glitch pulses
    // start in T2 and in the done cycle.
    task automatic applyStimulus(input logic [31:0] instr, input int stall, input bit glitch);
        for (int i = 1; i <= MAXC; i++) begin
            s_str[i] = '0; s_ro[i] = '0; s_ri[i] = '0; s_alu[i] = '0;
        end
        ncyc = 0; cnt_mem_read = 0; cnt_pc_in = 0; cnt_mdr_in = 0; any_load = 1'b0;
        ir        = instr;
        mem_ready = (stall == 0);
        start     = 1'b1;
        for (int k = 1; k <= MAXC; k++) begin
            tick();
            mem_ready = (stall == 0) || (k >= 2 + stall);
            start     = glitch && (k == 3);
            #1;
            s_str[k] = obs_strobes();
            s_ro[k]  = reg_out;
            s_ri[k]  = reg_in;
            s_alu[k] = alu_op;
            cnt_mem_read += int'(mem_read);
            cnt_pc_in    += int'(pc_in);
            cnt_mdr_in   += int'(mdr_in);
            any_load      = any_load | (|reg_in) | hi_in | lo_in;
            if (done) begin
                ncyc  = k;
                start = glitch;
                break;
            end
        end
        checkOutput("done_seen", 32'(ncyc != 0), 32'd1);
        tick();
        start = 1'b0;
        idle1_str = obs_strobes();
        tick();
        idle2_str = obs_strobes();
    endtask

    always @(negedge clk) begin
        if (monitor_on) begin
            checkOutput("bus_single_driver",
                        32'($countones({reg_out, pc_out, mdr_out, zlo_out, zhi_out}) <= 1), 32'd1);
            checkOutput("reg_in_onehot", 32'($countones(reg_in) <= 1), 32'd1);
            checkOutput("idle_no_load",
                        32'(busy || ({reg_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in} == '0)),
                        32'd1);
        end
    end

    initial begin
        logic [31:0] add_ir, mul_ir, ill_ir, neg_ir;
        add_ir = 32'h1A920000;
        mul_ir = 32'h7B380000;
        ill_ir = 32'hF8000000;
        neg_ir = {5'b10001, 4'd3, 4'd9, 4'd0, 15'd0};

        reset = 1'b1; start = 1'b0; mem_ready = 1'b0; ir = '0;
        repeat (2) tick();
        reset = 1'b0;
        monitor_on = 1'b1;
        tick();
        checkIdle("reset_state");

        $display("[TB] reset in the middle of an add");
        ir = add_ir; mem_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        checkOutput("rst pre T4 ro", 32'(reg_out), 32'h10);
        reset = 1'b1;
        tick();
        checkIdle("rst c1");
        tick();
        checkIdle("rst c2");
        reset = 1'b0;
        tick();
        checkIdle("rst after");

        $display("[TB] add R5,R2,R4");
        applyStimulus(add_ir, 0, 1'b0);
        checkOutput("add cycles", 32'(ncyc), 32'd6);
        checkCycle("add", 1, E_T0, 16'h0, 16'h0, 5'd0);
        checkCycle("add", 2, E_T1, 16'h0, 16'h0, 5'd0);
        checkCycle("add", 3, E_T2, 16'h0, 16'h0, 5'd0);
        checkCycle("add", 4, S_Y_IN | S_BUSY, 16'h0004, 16'h0, 5'd0);
        checkCycle("add", 5, S_Z_IN | S_BUSY, 16'h0010, 16'h0, 5'b00011);
        checkCycle("add", 6, S_ZLO_OUT | S_DONE | S_BUSY, 16'h0, 16'h0020, 5'd0);
        checkOutput("add idle", 32'(idle1_str), 32'd0);

        $display("[TB] add with three memory stall cycles");
        applyStimulus(add_ir, 3, 1'b0);
        checkOutput("stall cycles", 32'(ncyc), 32'd9);
        checkOutput("stall mem_read cnt", 32'(cnt_mem_read), 32'd4);
        checkOutput("stall pc_in cnt", 32'(cnt_pc_in), 32'd1);
        checkOutput("stall mdr_in cnt", 32'(cnt_mdr_in), 32'd1);
        checkCycle("stall", 2, E_T1_STALL, 16'h0, 16'h0, 5'd0);
        checkCycle("stall", 4, E_T1_STALL, 16'h0, 16'h0, 5'd0);
        checkCycle("stall", 5, E_T1, 16'h0, 16'h0, 5'd0);
        checkCycle("stall", 9, S_ZLO_OUT | S_DONE | S_BUSY, 16'h0, 16'h0020, 5'd0);

        $display("[TB] mul R6,R7");
        applyStimulus(mul_ir, 0, 1'b0);
        checkOutput("mul cycles", 32'(ncyc), 32'd7);
        checkCycle("mul", 4, S_Y_IN | S_BUSY, 16'h0040, 16'h0, 5'd0);
        checkCycle("mul", 5, S_Z_IN | S_BUSY, 16'h0080, 16'h0, 5'b01111);
        checkCycle("mul", 6, S_ZLO_OUT | S_LO_IN | S_BUSY, 16'h0, 16'h0, 5'd0);
        checkCycle("mul", 7, S_ZHI_OUT | S_HI_IN | S_DONE | S_BUSY, 16'h0, 16'h0, 5'd0);

        $display("[TB] neg R3,R9");
        applyStimulus(neg_ir, 0, 1'b0);
        checkOutput("neg cycles", 32'(ncyc), 32'd5);
        checkCycle("neg", 4, S_Z_IN | S_BUSY, 16'h0200, 16'h0, 5'b10001);
        checkCycle("neg", 5, S_ZLO_OUT | S_DONE | S_BUSY, 16'h0, 16'h0008, 5'd0);

        $display("[TB] undefined opcode");
        applyStimulus(ill_ir, 0, 1'b0);
        checkOutput("ill cycles", 32'(ncyc), 32'd4);
        checkCycle("ill", 4, S_DONE | S_ILLEGAL | S_BUSY, 16'h0, 16'h0, 5'd0);
        checkOutput("ill any_load", 32'(any_load), 32'd0);
        checkOutput("ill idle", 32'(idle1_str), 32'd0);

        $display("[TB] start pulsed in T2 and in the done cycle");
        applyStimulus(add_ir, 0, 1'b1);
        checkOutput("glitch cycles", 32'(ncyc), 32'd6);
        checkCycle("glitch", 4, S_Y_IN | S_BUSY, 16'h0004, 16'h0, 5'd0);
        checkOutput("glitch idle1", 32'(idle1_str), 32'd0);
        checkOutput("glitch idle2", 32'(idle2_str), 32'd0);

        monitor_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
